// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result bundle for the nibble-serial adder sequencer.
// Optional SIGNED_OVF_EN macro adds the ovf result bit.
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // Handshake: start is sampled only while idle, together with sub/a/b.
  // busy is high while nibbles are being processed; done is a one-cycle
  // pulse after the last nibble, and sum/cout hold until the next accept.
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SIGNED_OVF_EN
  logic         ovf;
`endif

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout
`ifdef SIGNED_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout
`ifdef SIGNED_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle add/subtract sequencer reusing one 4-bit ripple slice, LSB nibble first.
// Optional macro SIGNED_OVF_EN adds a two's-complement overflow flag (bus.ovf).
module nibble_serial_adder_fa4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);
  logic [4:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign co = c[4];
  assign c3 = c[3];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  nibble_serial_adder_ctrl_if.slave  bus,
  output logic [1:0]                 dbg_state
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic            carry;
  logic            sub_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            accept;
  logic            last;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      slice_s;
  logic            slice_co;
  logic            slice_c3;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign last      = (idx == IW'(NIBBLES - 1));
  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign dbg_state = state;

  // ---------------- datapath ----------------
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  // Subtraction is a + ~b + 1: invert b here, the +1 comes from carry=sub at accept.
  nibble_serial_adder_fa4 u_slice (
    .x  (a_nib),
    .y  (b_nib ^ {4{sub_q}}),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      idx    <= '0;
      carry  <= bus.sub;
      sub_q  <= bus.sub;
      a_q    <= bus.a;
      b_q    <= bus.b;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (state == RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx == IW'(i)) sum_q[4*i +: 4] <= slice_s;
      end
      carry <= slice_co;
      idx   <= idx + 1'b1;
      if (last) cout_q <= slice_co;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

`ifdef SIGNED_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ovf_q <= 1'b0;
    else if (accept)                ovf_q <= 1'b0;
    else if (state == RUN && last)  ovf_q <= slice_c3 ^ slice_co;
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_c3;
  assign unused_c3 = slice_c3;
`endif
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl at NIBBLES=4 and NIBBLES=1.
module tb_nibble_serial_adder_ctrl;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg4;
  logic [1:0] dbg1;
  int         n_checks;
  int         n_errors;

  nibble_serial_adder_ctrl_if #(.NIBBLES(4)) bus4 ();
  nibble_serial_adder_ctrl_if #(.NIBBLES(1)) bus1 ();

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus4.slave),
    .dbg_state (dbg4)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1.slave),
    .dbg_state (dbg1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one operation on the 4-nibble DUT and check handshake timing and result.
  task automatic do_op(input string tag, input logic sub_i, input logic [15:0] a_i,
                       input logic [15:0] b_i, input logic [15:0] exp_sum,
                       input logic exp_cout, input logic exp_ovf);
    int cyc;
    int busy_cnt;
    bus4.start = 1'b1;
    bus4.sub   = sub_i;
    bus4.a     = a_i;
    bus4.b     = b_i;
    @(negedge clk);
    bus4.start = 1'b0;
    check({tag, "_cleared_sum"}, 64'(bus4.sum), 64'h0);
    check({tag, "_cleared_cout"}, 64'(bus4.cout), 64'h0);
    cyc      = 1;
    busy_cnt = 0;
    while (!bus4.done && cyc < 30) begin
      if (bus4.busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(bus4.done), 64'h1);
    check({tag, "_latency"}, 64'(cyc), 64'd5);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
    check({tag, "_sum"}, 64'(bus4.sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(bus4.cout), 64'(exp_cout));
`ifdef SIGNED_OVF_EN
    check({tag, "_ovf"}, 64'(bus4.ovf), 64'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unexpected ovf expectation in %s", tag);
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus4.done), 64'h0);
    check({tag, "_sum_held"}, 64'(bus4.sum), 64'(exp_sum));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    logic [15:0] sum_at_done;
    logic        cout_at_done;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    bus4.start = 1'b0;
    bus4.sub   = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    bus1.start = 1'b0;
    bus1.sub   = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;
    repeat (2) @(negedge clk);

    check("rst_busy", 64'(bus4.busy), 64'h0);
    check("rst_done", 64'(bus4.done), 64'h0);
    check("rst_sum", 64'(bus4.sum), 64'h0);
    check("rst_cout", 64'(bus4.cout), 64'h0);
    check("rst_state", 64'(dbg4), 64'h0);
`ifdef SIGNED_OVF_EN
    check("rst_ovf", 64'(bus4.ovf), 64'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    do_op("add_basic", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
    do_op("add_ripple", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    do_op("sub_borrow", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

    // Start and operand changes while busy must not disturb the operation.
    bus4.start = 1'b1;
    bus4.sub   = 1'b0;
    bus4.a     = 16'h1111;
    bus4.b     = 16'h2222;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    check("ignore_busy2", 64'(bus4.busy), 64'h1);
    bus4.start = 1'b1;
    bus4.sub   = 1'b1;
    bus4.a     = 16'hFFFF;
    bus4.b     = 16'hFFFF;
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.a     = 16'h0000;
    bus4.b     = 16'h0000;
    pulses       = 0;
    sum_at_done  = '0;
    cout_at_done = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (bus4.done) begin
        pulses++;
        sum_at_done  = bus4.sum;
        cout_at_done = bus4.cout;
      end
      @(negedge clk);
    end
    check("ignore_pulses", 64'(pulses), 64'd1);
    check("ignore_sum", 64'(sum_at_done), 64'h3333);
    check("ignore_cout", 64'(cout_at_done), 64'h0);
    check("ignore_idle", 64'(bus4.busy), 64'h0);
    check("ignore_sum_held", 64'(bus4.sum), 64'h3333);

    // Asynchronous reset during the third RUN cycle.
    bus4.start = 1'b1;
    bus4.sub   = 1'b0;
    bus4.a     = 16'h1234;
    bus4.b     = 16'h0FFF;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", 64'(bus4.busy), 64'h1);
    check("mid_partial_sum", 64'(bus4.sum), 64'h0033);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus4.busy), 64'h0);
    check("arst_done", 64'(bus4.done), 64'h0);
    check("arst_sum", 64'(bus4.sum), 64'h0);
    check("arst_cout", 64'(bus4.cout), 64'h0);
    @(negedge clk);
    @(negedge clk);
    check("arst_no_done", 64'(bus4.done), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("after_rst", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

    // Single-nibble instance: RUN lasts one cycle.
    bus1.start = 1'b1;
    bus1.sub   = 1'b0;
    bus1.a     = 4'hF;
    bus1.b     = 4'h1;
    @(negedge clk);
    bus1.start = 1'b0;
    check("n1_busy", 64'(bus1.busy), 64'h1);
    check("n1_not_done", 64'(bus1.done), 64'h0);
    @(negedge clk);
    check("n1_done", 64'(bus1.done), 64'h1);
    check("n1_sum", 64'(bus1.sum), 64'h0);
    check("n1_cout", 64'(bus1.cout), 64'h1);
`ifdef SIGNED_OVF_EN
    check("n1_ovf", 64'(bus1.ovf), 64'h0);
`endif
    @(negedge clk);
    check("n1_done_pulse", 64'(bus1.done), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
